mod_reduce_seq: RTL and testbench
=================================

# mod_reduce_seq

Sequential modular reducer placed directly downstream of the Karatsuba multiplier pipeline. Accepts its 384-bit product word `P` on a valid pulse, computes `R = P mod MOD` for a fixed 128-bit modulus by MSB-first restoring reduction, processing `STEPS` bits per cycle. It presents the result with a valid/ready handshake. The multiplier has no backpressure, so products that arrive while the reducer is busy are dropped and flagged.

## Interface
- `IN_W`, 384: input operand width; must be a multiple of `STEPS`.
- `STEPS`, 4: bits consumed per RUN cycle (unrolled restoring steps).
- `MOD`, 128'h7fffffffffffffffffffffffffffffff: modulus; nonzero, fits in 128 bits.
- `clock`  input  1  sole clock, rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  product valid; driven by the multiplier `out_valid`.
- `P`  input  IN_W  product to reduce; sampled only on accept.
- `in_ready`  output  1  high only in IDLE.
- `R`  output  128  remainder; held stable while `out_valid` is high.
- `out_valid`  output  1  result valid.
- `out_ready`  input  1  consumer accepts result.
- `drop`  output  1  sticky; set when `in_valid` is high and `in_ready` is low.

## Operation
- States: IDLE, RUN, DONE. Reset puts the block in IDLE with `R`=0, `out_valid`=0, `drop`=0. `in_ready` is 1 whenever the state is IDLE.
- IDLE, on `in_valid`: load the shift register with `P`, clear remainder `r` (129 bits), load the count with `N = IN_W/STEPS`, then go to RUN.
- RUN, each cycle, for `STEPS` steps MSB-first:
  - `r = 2r + nextbit`.
  - If `r >= MOD`, then `r = r - MOD`.
  - Invariant: `r < MOD` after every step. 129-bit intermediate, no overflow.
- RUN, when the count reaches 0 after its last cycle: `R` takes `r[127:0]`, `out_valid` is set to 1, and the state goes to DONE.
- DONE: hold `R` and `out_valid`. On `out_ready`=1, clear `out_valid` and return to IDLE at that edge.
- `drop`: set on any edge where `in_valid`=1 in RUN or DONE. It is cleared only by reset. The dropped product is discarded and the in-flight operation is unaffected.
- `in_valid` in IDLE coincident with a previous DONE exit is impossible, because the IDLE entry edge precedes acceptance.
- Reset asserted mid-RUN or mid-DONE: all state clears immediately (asynchronously). The result is lost and no `out_valid` is produced.

## Timing
- Accept edge is t0. `out_valid` rises at edge t0+N. At the defaults, N=96.
- Minimum spacing between accepts is N+2 cycles, with `out_ready` tied high.
- `R` changes only on the edge that raises `out_valid`.
- The critical path is `STEPS` chained 129-bit compare/subtract stages. `STEPS` trades cycles for depth.

## Configuration
- `MODRED_ZERO_SKIP_EN` defined:
  - At accept, if `P[IN_W-1:IN_W-128]` is all zero, the shift register starts at bit `IN_W-129`, and the count loads `(IN_W-128)/STEPS`. At the defaults this is 64 cycles, and `out_valid` rises at t0+64.
  - Otherwise the count loads N, as normal.
  - Requires `(IN_W-128)` to be a multiple of `STEPS`.
- Undefined: latency is always N, regardless of data.
- The result value is identical in both builds.

## Test plan
- `P`=0, `out_ready`=1: `R`=0, and `out_valid` is a one-cycle pulse at t0+96 (t0+64 with `MODRED_ZERO_SKIP_EN`).
- `P`=2^127 then `P`=2^256-1, default MOD: the first gives `R`=1, the second gives `R`=3.
- `P`=MOD gives `R`=0. `P`=MOD-1 gives `R`=MOD-1. `P`=2^383 gives `R`=2^(383 mod 127)=2^2=4.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid` rises. `R` stays stable and `in_ready` stays 0. An `in_valid` pulse in that window sets `drop`=1, which stays 1. After `out_ready`, the next accept succeeds and gives a correct result.
- Reset pulse 40 cycles into RUN: `in_ready`=1 and `out_valid`=0 immediately, and `drop`=0. A new product accepted afterwards gives the correct `R` with full latency.
- Random regression of 10k products against a reference `%` model, with random `out_ready` stalls and no upstream overlap: zero mismatches and `drop`=0.

Source files
------------

// File: rtl/mod_reduce_seq.sv
// Sequential MSB-first restoring reducer: R = P mod MOD, STEPS bits per cycle.
// Optional build macro MODRED_ZERO_SKIP_EN skips an all-zero top 128-bit limb at accept.
module mod_reduce_seq #(
  parameter int            IN_W  = 384,
  parameter int            STEPS = 4,
  parameter logic [127:0]  MOD   = 128'h7fffffffffffffffffffffffffffffff
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [IN_W-1:0] P,
  output logic            in_ready,
  output logic [127:0]    R,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            drop
);

  localparam int N  = IN_W / STEPS;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_next;
  logic [IN_W-1:0] shift_reg;
  logic [127:0]    rem;
  logic [CW-1:0]   count;
  logic [128:0]    rem_step;

  // One restoring step: the remainder stays below MOD, so 2r+1 always fits in 129 bits.
  function automatic logic [128:0] reduce_step(input logic [128:0] r_in, input logic b);
    logic [128:0] t;
    t = {r_in[127:0], b};
    if (t >= {1'b0, MOD})
      t = t - {1'b0, MOD};
    return t;
  endfunction

  always_comb begin
    rem_step = {1'b0, rem};
    for (int i = 0; i < STEPS; i++)
      rem_step = reduce_step(rem_step, shift_reg[IN_W-1-i]);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = RUN;
      RUN:  if (count == CW'(1)) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shift_reg <= '0;
      rem       <= '0;
      count     <= '0;
      R         <= '0;
      out_valid <= 1'b0;
      drop      <= 1'b0;
    end else begin
      if (in_valid && state != IDLE)
        drop <= 1'b1;
      case (state)
        IDLE: begin
          if (in_valid) begin
            rem <= '0;
`ifdef MODRED_ZERO_SKIP_EN
            // A zero top limb contributes nothing, so start right below it.
            if (P[IN_W-1:IN_W-128] == '0) begin
              shift_reg <= {P[IN_W-129:0], 128'b0};
              count     <= CW'((IN_W - 128) / STEPS);
            end else begin
              shift_reg <= P;
              count     <= CW'(N);
            end
`else
            shift_reg <= P;
            count     <= CW'(N);
`endif
          end
        end
        RUN: begin
          rem       <= rem_step[127:0];
          shift_reg <= {shift_reg[IN_W-STEPS-1:0], {STEPS{1'b0}}};
          count     <= count - CW'(1);
          if (count == CW'(1)) begin
            R         <= rem_step[127:0];
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready)
            out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_reduce_seq.sv
// Directed and light random bench for mod_reduce_seq against a % reference model.
module tb_mod_reduce_seq;

  localparam logic [127:0] MOD = 128'h7fffffffffffffffffffffffffffffff;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [383:0] P;
  logic         in_ready;
  logic [127:0] R;
  logic         out_valid;
  logic         out_ready;
  logic         drop;

  int checks = 0;
  int passes = 0;

  mod_reduce_seq dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .P(P),
    .in_ready(in_ready), .R(R), .out_valid(out_valid),
    .out_ready(out_ready), .drop(drop)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [383:0] observed,
                             input logic [383:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  function automatic int expLat(input logic [383:0] p);
`ifdef MODRED_ZERO_SKIP_EN
    if (p[383:256] == '0) return 64;
`endif
    return 96;
  endfunction

  // Accept one product, wait (bounded) for the result, optionally stall the consumer.
  task automatic applyStimulus(input logic [383:0] p, input int stall,
                               input bit injectDrop, input string tag);
    logic [383:0] modW, full;
    logic [127:0] expR, held;
    int           lat, k;
    bit           seen, stable;
    modW = {256'b0, MOD};
    full = p % modW;
    expR = full[127:0];
    lat  = expLat(p);
    out_ready = (stall == 0);
    in_valid  = 1'b1;
    P         = p;
    @(posedge clock); #1;
    in_valid = 1'b0;
    P        = '0;
    k = 0;
    seen = 1'b0;
    while (!seen && k < lat + 20) begin
      @(posedge clock); #1;
      k++;
      if (out_valid) seen = 1'b1;
    end
    checkOutput({tag, ".latency"}, 384'(k), 384'(lat));
    if (!seen) return;
    checkOutput({tag, ".R"}, {256'b0, R}, {256'b0, expR});
    held   = R;
    stable = 1'b1;
    for (int i = 0; i < stall; i++) begin
      if (injectDrop && i == 2) begin
        in_valid = 1'b1;
        P        = ~p;
      end
      @(posedge clock); #1;
      in_valid = 1'b0;
      if (R !== held || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
    end
    if (stall > 0) checkOutput({tag, ".stallHold"}, 384'(stable), 384'(1));
    out_ready = 1'b1;
    @(posedge clock); #1;
    checkOutput({tag, ".validFall"}, 384'(out_valid), 384'(0));
    checkOutput({tag, ".readyBack"}, 384'(in_ready), 384'(1));
  endtask

  initial begin
    logic [383:0] rp;
    logic [383:0] modFull;
    modFull   = {256'b0, MOD};
    reset     = 1'b0;
    in_valid  = 1'b0;
    P         = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset.inReady", 384'(in_ready), 384'(1));
    checkOutput("reset.outValid", 384'(out_valid), 384'(0));
    checkOutput("reset.drop", 384'(drop), 384'(0));
    checkOutput("reset.R", {256'b0, R}, 384'(0));
    reset = 1'b1;
    @(posedge clock); #1;

    applyStimulus('0, 0, 1'b0, "zero");
    applyStimulus(384'(1) << 127, 0, 1'b0, "pow127");
    applyStimulus((384'(1) << 256) - 384'(1), 0, 1'b0, "pow256m1");
    applyStimulus(modFull, 0, 1'b0, "mod");
    applyStimulus(modFull - 384'(1), 0, 1'b0, "modm1");
    applyStimulus(384'(1) << 383, 0, 1'b0, "pow383");
    applyStimulus({384{1'b1}}, 0, 1'b0, "allOnes");
    applyStimulus(modFull * 384'(5) + 384'(17), 1, 1'b0, "mod5p17");

    for (int n = 0; n < 12; n++) begin
      for (int w = 0; w < 12; w++) rp[w*32 +: 32] = $urandom;
      if (n == 3) rp[383:256] = '0;
      applyStimulus(rp, $urandom_range(0, 3), 1'b0, $sformatf("rand%0d", n));
    end
    checkOutput("rand.dropClear", 384'(drop), 384'(0));

    applyStimulus({128'h0123456789abcdef0011223344556677, 256'hdeadbeef}, 10, 1'b1, "backpressure");
    checkOutput("bp.dropSet", 384'(drop), 384'(1));
    applyStimulus((384'(1) << 200) + 384'(12345), 0, 1'b0, "afterBp");
    checkOutput("bp.dropSticky", 384'(drop), 384'(1));

    // Asynchronous reset 40 cycles into RUN must clear everything at once.
    in_valid = 1'b1;
    P        = {384{1'b1}};
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (40) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midReset.inReady", 384'(in_ready), 384'(1));
    checkOutput("midReset.outValid", 384'(out_valid), 384'(0));
    checkOutput("midReset.drop", 384'(drop), 384'(0));
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    applyStimulus(384'(1) << 383, 0, 1'b0, "postReset");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
